// File: rtl/fifo_seq_ctrl.sv
// Load/drain sequencer for a bank of ROWS shift-on-enable delay fifos feeding a systolic array.
// Loads DEPTH column beats, then drains with a one-cycle-per-row diagonal skew.
module fifo_seq_ctrl #(
  parameter int unsigned ROWS  = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ROWS*BITS-1:0] in_data,
  output logic [ROWS-1:0]      fifo_en,
  output logic [ROWS*BITS-1:0] fifo_d,
  output logic [ROWS-1:0]      row_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned LoadW    = $clog2(DEPTH);
  localparam int unsigned DrainMax = DEPTH + ROWS - 2;
  localparam int unsigned DrainW   = $clog2(DrainMax + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StDone} state_e;

  state_e            state_q;
  logic [LoadW-1:0]  load_cnt_q;
  logic [DrainW-1:0] drain_cnt_q;
  logic              accept;

  assign in_ready = (state_q == StLoad);
  assign accept   = in_valid && in_ready;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      load_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StLoad;
            load_cnt_q <= '0;
          end
        end
        StLoad: begin
          if (accept) begin
            if (load_cnt_q == LoadW'(DEPTH - 1)) begin
              state_q     <= StDrain;
              load_cnt_q  <= '0;
              drain_cnt_q <= '0;
            end else begin
              load_cnt_q <= load_cnt_q + LoadW'(1);
            end
          end
        end
        StDrain: begin
          if (drain_cnt_q == DrainW'(DrainMax)) begin
            state_q <= StDone;
          end else begin
            drain_cnt_q <= drain_cnt_q + DrainW'(1);
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    int unsigned dc;
    fifo_en   = '0;
    fifo_d    = '0;
    row_valid = '0;
    dc        = 32'(drain_cnt_q);
    case (state_q)
      StLoad: begin
        if (accept) begin
          fifo_en = '1;
          fifo_d  = in_data;
        end
      end
      StDrain: begin
        // Row i shifts for DEPTH cycles starting i cycles after row 0; zeros are shifted in.
        for (int unsigned i = 0; i < ROWS; i++) begin
          fifo_en[i] = (dc >= i) && (dc < i + DEPTH);
        end
        row_valid = fifo_en;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/fifo_seq_ctrl.md
# fifo_seq_ctrl

Sequencer for a bank of ROWS delay fifos (DEPTH entries × BITS wide, shift-on-enable, oldest entry on q) that feed a systolic array. A pass runs in two phases. First it loads DEPTH column beats from an upstream valid/ready source, shifting all fifos together. Then it drains them with a one-cycle-per-row diagonal skew, so row i starts emitting i cycles after row 0. It sits between the host/MMIO load path and the fifo bank, and owns every fifo shift-enable and data input.

## Interface
- ROWS, 8, number of fifos in the bank (≥2)
- DEPTH, 8, entries per fifo (≥2)
- BITS, 8, width of one fifo entry
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a pass; sampled only in IDLE
- in_valid  input  1  column beat on in_data is valid
- in_ready  output  1  controller accepts a beat this cycle
- in_data  input  ROWS*BITS  column beat; slice [i*BITS +: BITS] goes to fifo i
- fifo_en  output  ROWS  per-fifo shift enable
- fifo_d  output  ROWS*BITS  per-fifo data input; slice i drives fifo i
- row_valid  output  ROWS  fifo i's q is a valid operand for the array this cycle
- busy  output  1  pass in progress (LOAD, DRAIN, DONE)
- done  output  1  one-cycle pulse at end of pass

## Operation
- States: IDLE, LOAD, DRAIN, DONE. Counters: load_cnt (0..DEPTH-1) and drain_cnt (0..DEPTH+ROWS-2), each $clog2-sized to hold its maximum.
- IDLE: start=1 → LOAD and clear load_cnt. Otherwise stay in IDLE.
- LOAD: in_ready=1. The accept condition is in_valid&&in_ready.
  - On accept: fifo_en={ROWS{1}}, fifo_d=in_data, and load_cnt increments.
  - On the accept with load_cnt==DEPTH-1: → DRAIN, drain_cnt=0.
  - No accept: fifo_en=0 and no count change.
- DRAIN: in_ready=0, fifo_d=0 (zeros shifted in).
  - fifo_en[i]=1 iff i ≤ drain_cnt < i+DEPTH.
  - row_valid=fifo_en.
  - drain_cnt increments each cycle. At drain_cnt==DEPTH+ROWS-2 → DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then → IDLE.
- row_valid=0 in every state except DRAIN.
- start outside IDLE is ignored. It is neither queued nor allowed to restart the pass.
- in_data is ignored whenever in_ready=0.
- Each fifo is shifted exactly DEPTH times per phase. After DRAIN the whole bank holds zeros.

## Timing
- Reset (async assert, any state): state=IDLE, counters=0, and in_ready, fifo_en, fifo_d, row_valid, busy, done all 0. Reset mid-pass abandons the pass. No done pulse is issued.
- Registered: state, load_cnt, drain_cnt.
- Combinational from state/counters: in_ready, busy, done, fifo_en, row_valid, fifo_d. fifo_en/fifo_d also depend combinationally on in_valid/in_data in LOAD. The fifo registers the beat at the same edge that accepts it.
- start high at edge t in IDLE → LOAD and in_ready=1 from cycle t+1.
- Last load beat accepted at edge u → DRAIN in cycles u+1 .. u+DEPTH+ROWS-1. In drain cycle k, row i presents its loaded entry k-i (0 = first loaded).
- done high in cycle u+DEPTH+ROWS, IDLE from cycle u+DEPTH+ROWS+1. start may be accepted in that first IDLE cycle.
- Minimum pass length with no bubbles: 1 + DEPTH + (DEPTH+ROWS-1) + 1 cycles from the start edge.

## Test plan
All scenarios use ROWS=4, DEPTH=4, BITS=8, with a behavioural model of 4 fifos attached.
- Reset asserted, then released with start=0 → all outputs 0 and busy=0 for 10 cycles.
- start pulse, then in_valid held high with beats 0x04030201, 0x08070605, 0x0C0B0A09, 0x100F0E0D → in_ready=1 for exactly 4 cycles, fifo_en=4'hF on each, DRAIN entered on the next cycle.
- Same load with in_valid low on alternate cycles → fifo_en=0 and load_cnt frozen during gaps; DRAIN entered only after the 4th accepted beat.
- Drain after the load above → fifo_en/row_valid sequence 0001, 0011, 0111, 1111, 1110, 1100, 1000, and fifo_d=0 throughout.
  - Row 0 q values: 0x01, 0x05, 0x09, 0x0D.
  - Row 3 q values: 0x04, 0x08, 0x0C, 0x10, on drain cycles 3–6.
  - done=1 for one cycle afterwards.
- start pulsed during LOAD, DRAIN and DONE → no effect on counts or timing. start in the first IDLE cycle after done → new pass begins, in_ready=1 next cycle.
- rst_n pulsed low in drain cycle 2 → all outputs 0 immediately, state IDLE, no done pulse. A following full pass completes normally.
